// File: rtl/id_ex_reg_pp.sv
// ---------------------------------------------------------------------------
// id_ex_reg_pp
//   ID/EX pipeline register of the 5-stage pipelined MIPS core. Captures the
//   decoded control bits, register-file read data, sign-extended immediate and
//   register addresses at the end of ID and presents them to EX one clock
//   later. The ALU control decoder in EX reads ex_ALUOp and ex_funct directly
//   from this register.
//
//   Hazard-unit controls (priority per rising edge: reset > flush > stall > load)
//     flush : load a NOP bubble (all fields zero) and count it in bubble_cnt
//     stall : hold every output, bubble_cnt included
//
// Ports
//   clk, reset          : clock, asynchronous active-high clear
//   stall, flush        : hazard-unit hold / bubble request
//   id_valid            : ID holds a real instruction
//   id_<ctrl>, id_ALUOp : decoded control from main control
//   id_pc4, id_rd1,
//   id_rd2, id_imm      : DATA_W-wide data fields
//   id_rs, id_rt, id_rd : REG_ADDR_W-wide register addresses
//   ex_*                : registered copies of the above, ex_funct = imm[5:0]
//   bubble_cnt          : saturating count of bubbles inserted since reset
// ---------------------------------------------------------------------------
module id_ex_reg_pp #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_RegWrite,
  input  logic                  id_MemtoReg,
  input  logic                  id_MemRead,
  input  logic                  id_MemWrite,
  input  logic                  id_Branch,
  input  logic                  id_RegDst,
  input  logic                  id_ALUSrc,
  input  logic [1:0]            id_ALUOp,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  ex_valid,
  output logic                  ex_RegWrite,
  output logic                  ex_MemtoReg,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic                  ex_RegDst,
  output logic                  ex_ALUSrc,
  output logic [1:0]            ex_ALUOp,
  output logic [5:0]            ex_funct,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [7:0]            bubble_cnt
);

  // Saturating increment: sticks at 8'hFF rather than wrapping to zero.
  logic [7:0] bubble_cnt_inc;

  always_comb begin
    bubble_cnt_inc = bubble_cnt;
    if (bubble_cnt != '1) begin
      bubble_cnt_inc = bubble_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_funct    <= '0;
      ex_pc4      <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      // Bubble: every field cleared so no stale data or address can trigger
      // forwarding or a write downstream. Flush overrides a concurrent stall.
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_funct    <= '0;
      ex_pc4      <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      bubble_cnt  <= bubble_cnt_inc;
    end else if (!stall) begin
      // Normal load. An invalid ID slot still carries its data through, but
      // the state-changing controls are gated so it cannot write or branch.
      ex_valid    <= id_valid;
      ex_RegWrite <= id_RegWrite & id_valid;
      ex_MemtoReg <= id_MemtoReg;
      ex_MemRead  <= id_MemRead  & id_valid;
      ex_MemWrite <= id_MemWrite & id_valid;
      ex_Branch   <= id_Branch   & id_valid;
      ex_RegDst   <= id_RegDst;
      ex_ALUSrc   <= id_ALUSrc;
      ex_ALUOp    <= id_ALUOp;
      ex_funct    <= id_imm[5:0];
      ex_pc4      <= id_pc4;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_reg_pp.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg_pp
//   Scoreboard bench for id_ex_reg_pp: each driven cycle pushes the expected
//   EX-side state, which is popped and compared field by field after the edge.
// ---------------------------------------------------------------------------
module tb_id_ex_reg_pp;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  bubble;
  } ex_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        id_valid, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite;
  logic        id_Branch, id_RegDst, id_ALUSrc;
  logic [1:0]  id_ALUOp;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite;
  logic        ex_Branch, ex_RegDst, ex_ALUSrc;
  logic [1:0]  ex_ALUOp;
  logic [5:0]  ex_funct;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  bubble_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  ex_t  mdl;
  ex_t  sb_q[$];

  id_ex_reg_pp #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_funct(ex_funct), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one rising edge.
  function automatic ex_t next_state(ex_t cur, id_t s, bit st, bit fl, bit rs_);
    ex_t n;
    n = cur;
    if (rs_) begin
      n = '0;
    end else if (fl) begin
      n = '0;
      n.bubble = (cur.bubble == 8'hFF) ? 8'hFF : cur.bubble + 8'd1;
    end else if (!st) begin
      n.valid    = s.valid;
      n.regwrite = s.regwrite & s.valid;
      n.memtoreg = s.memtoreg;
      n.memread  = s.memread  & s.valid;
      n.memwrite = s.memwrite & s.valid;
      n.branch   = s.branch   & s.valid;
      n.regdst   = s.regdst;
      n.alusrc   = s.alusrc;
      n.aluop    = s.aluop;
      n.funct    = s.imm[5:0];
      n.pc4      = s.pc4;
      n.rd1      = s.rd1;
      n.rd2      = s.rd2;
      n.imm      = s.imm;
      n.rs       = s.rs;
      n.rt       = s.rt;
      n.rd       = s.rd;
    end
    return n;
  endfunction

  function automatic id_t rand_id();
    id_t r;
    r.valid    = 1'($urandom);
    r.regwrite = 1'($urandom);
    r.memtoreg = 1'($urandom);
    r.memread  = 1'($urandom);
    r.memwrite = 1'($urandom);
    r.branch   = 1'($urandom);
    r.regdst   = 1'($urandom);
    r.alusrc   = 1'($urandom);
    r.aluop    = 2'($urandom);
    r.pc4      = $urandom;
    r.rd1      = $urandom;
    r.rd2      = $urandom;
    r.imm      = $urandom;
    r.rs       = 5'($urandom);
    r.rt       = 5'($urandom);
    r.rd       = 5'($urandom);
    return r;
  endfunction

  task automatic pop_compare(input string tag);
    ex_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".valid"},    64'(ex_valid),    64'(e.valid));
    check({tag, ".RegWrite"}, 64'(ex_RegWrite), 64'(e.regwrite));
    check({tag, ".MemtoReg"}, 64'(ex_MemtoReg), 64'(e.memtoreg));
    check({tag, ".MemRead"},  64'(ex_MemRead),  64'(e.memread));
    check({tag, ".MemWrite"}, 64'(ex_MemWrite), 64'(e.memwrite));
    check({tag, ".Branch"},   64'(ex_Branch),   64'(e.branch));
    check({tag, ".RegDst"},   64'(ex_RegDst),   64'(e.regdst));
    check({tag, ".ALUSrc"},   64'(ex_ALUSrc),   64'(e.alusrc));
    check({tag, ".ALUOp"},    64'(ex_ALUOp),    64'(e.aluop));
    check({tag, ".funct"},    64'(ex_funct),    64'(e.funct));
    check({tag, ".pc4"},      64'(ex_pc4),      64'(e.pc4));
    check({tag, ".rd1"},      64'(ex_rd1),      64'(e.rd1));
    check({tag, ".rd2"},      64'(ex_rd2),      64'(e.rd2));
    check({tag, ".imm"},      64'(ex_imm),      64'(e.imm));
    check({tag, ".rs"},       64'(ex_rs),       64'(e.rs));
    check({tag, ".rt"},       64'(ex_rt),       64'(e.rt));
    check({tag, ".rd"},       64'(ex_rd),       64'(e.rd));
    check({tag, ".bubble"},   64'(bubble_cnt),  64'(e.bubble));
  endtask

  // Drive one cycle at the falling edge, predict, compare 1 time unit after
  // the rising edge.
  task automatic drive_cycle(input string tag, input id_t s, input bit st,
                             input bit fl, input bit rs_);
    @(negedge clk);
    reset       = rs_;
    stall       = st;
    flush       = fl;
    id_valid    = s.valid;
    id_RegWrite = s.regwrite;
    id_MemtoReg = s.memtoreg;
    id_MemRead  = s.memread;
    id_MemWrite = s.memwrite;
    id_Branch   = s.branch;
    id_RegDst   = s.regdst;
    id_ALUSrc   = s.alusrc;
    id_ALUOp    = s.aluop;
    id_pc4      = s.pc4;
    id_rd1      = s.rd1;
    id_rd2      = s.rd2;
    id_imm      = s.imm;
    id_rs       = s.rs;
    id_rt       = s.rt;
    id_rd       = s.rd;
    mdl = next_state(mdl, s, st, fl, rs_);
    sb_q.push_back(mdl);
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  // Assert reset between edges and expect an immediate clear.
  task automatic async_reset(input string tag);
    #1;
    reset = 1'b1;
    mdl = '0;
    sb_q.push_back(mdl);
    #1;
    pop_compare(tag);
  endtask

  id_t rtype, lw, sw, inv, nop_id;

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_RegWrite = 1'b0; id_MemtoReg = 1'b0; id_MemRead = 1'b0;
    id_MemWrite = 1'b0; id_Branch = 1'b0; id_RegDst = 1'b0; id_ALUSrc = 1'b0;
    id_ALUOp = '0; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    mdl    = '0;
    nop_id = '0;

    async_reset("reset_init");
    drive_cycle("reset_hold", rand_id(), 1'b0, 1'b0, 1'b1);

    rtype = '0;
    rtype.valid = 1'b1; rtype.regwrite = 1'b1; rtype.regdst = 1'b1;
    rtype.aluop = 2'b10; rtype.imm = 32'h0000_0022; rtype.pc4 = 32'h0000_0104;
    rtype.rd1 = 32'd5; rtype.rd2 = 32'd3; rtype.rs = 5'd1; rtype.rt = 5'd2; rtype.rd = 5'd3;
    drive_cycle("load_rtype", rtype, 1'b0, 1'b0, 1'b0);
    check("rtype_funct", 64'(ex_funct), 64'(6'b100010));

    lw = '0;
    lw.valid = 1'b1; lw.regwrite = 1'b1; lw.memread = 1'b1; lw.memtoreg = 1'b1;
    lw.alusrc = 1'b1; lw.aluop = 2'b00; lw.imm = 32'd8; lw.rd1 = 32'h1000_0000;
    lw.pc4 = 32'h0000_0108; lw.rs = 5'd4; lw.rt = 5'd6;
    drive_cycle("load_lw", lw, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle("stall_hold", rand_id(), 1'b1, 1'b0, 1'b0);
    check("stall_imm", 64'(ex_imm), 64'd8);

    sw = '0;
    sw.valid = 1'b1; sw.memwrite = 1'b1; sw.alusrc = 1'b1; sw.imm = 32'd12;
    sw.rd1 = 32'h20; sw.rd2 = 32'h99; sw.rs = 5'd7; sw.rt = 5'd8;
    drive_cycle("flush_sw", sw, 1'b0, 1'b1, 1'b0);
    drive_cycle("flush_stall", rtype, 1'b1, 1'b1, 1'b0);
    drive_cycle("load_after_fs", rtype, 1'b0, 1'b0, 1'b0);

    inv = rtype;
    inv.valid = 1'b0; inv.memwrite = 1'b1; inv.memread = 1'b1; inv.branch = 1'b1;
    inv.memtoreg = 1'b1; inv.alusrc = 1'b1;
    drive_cycle("invalid_load", inv, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      drive_cycle("random_mix", rand_id(), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), 1'b0);

    // Reset arriving mid-stall, then held across an edge with flush high.
    drive_cycle("pre_reset_load", lw, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    stall = 1'b1;
    async_reset("reset_midstall");
    drive_cycle("reset_over_flush", sw, 1'b0, 1'b1, 1'b1);
    drive_cycle("post_reset_load", rtype, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) drive_cycle("saturate", rand_id(), 1'b0, 1'b1, 1'b0);
    check("bubble_sat", 64'(bubble_cnt), 64'(8'hFF));
    drive_cycle("post_sat_load", sw, 1'b0, 1'b0, 1'b0);
    drive_cycle("post_sat_flush", nop_id, 1'b0, 1'b1, 1'b0);

    if (sb_q.size() != 0) check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
